// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch FSM encoding and PC constants.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_state_e;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control inputs and fetch outputs of the PC/fetch stage.
interface pc_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        trap;
  logic [31:0] trap_pc;
  logic [1:0]  state;

  // Control side: decode/execute drives redirects and watches the fetch address
  modport master (
    output stall, branch_taken, branch_offset, jump, jump_index, jr, jr_target, halt,
    input  pc, pc_plus4, fetch_valid, trap, trap_pc, state
  );

  // Fetch unit side
  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_index, jr, jr_target, halt,
    output pc, pc_plus4, fetch_valid, trap, trap_pc, state
  );
endinterface

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-PC mux: picks the redirect source by priority and flags a misaligned jr.
module pc_next_sel (
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  // jr > jump > branch > sequential; only jr can produce an unaligned target
  always_comb begin
    next_pc  = pc_plus4;
    misalign = 1'b0;
    if (jr) begin
      next_pc  = jr_target;
      misalign = (jr_target[1:0] != 2'b00);
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + (branch_offset << 2);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and boot/run/halt sequencing for the fetch stage.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,   // active low, asynchronous
  pc_fetch_unit_if.slave    bus
);

  fsm_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        misalign;

  assign pc_plus4 = pc_q + WORD_BYTES;

  pc_next_sel u_sel (
    .pc_plus4      (pc_plus4),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .jump          (bus.jump),
    .jump_index    (bus.jump_index),
    .jr            (bus.jr),
    .jr_target     (bus.jr_target),
    .next_pc       (next_pc),
    .misalign      (misalign)
  );

  // Next state: trap beats halt, halt beats any redirect, stall freezes everything
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.stall) begin
          if (misalign) begin
            trap_d    = 1'b1;
            trap_pc_d = bus.jr_target;
            state_d   = HALT;
          end else if (bus.halt) begin
            state_d = HALT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
    fetch_valid_d = (state_d == RUN);
  end

  // Architectural state; reset clears everything without waiting for clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      trap_q        <= 1'b0;
      trap_pc_q     <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      trap_q        <= trap_d;
      trap_pc_q     <= trap_pc_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.trap        = trap_q;
  assign bus.trap_pc     = trap_pc_q;
  assign bus.state       = state_q;

endmodule
